// File: rtl/instr_pack.sv
// Shared definitions for the 9-bit CPU control path.
//   seq_state_t    : sequencer state encoding (IDLE, RUN, HALT, FAULT)
//   SUB_BASE_DEF   : default address of subroutine 0
//   SUB_STRIDE_DEF : default spacing between subroutine entry points
//   JSR_IDX_W      : width of the jtsr subroutine index
package instr_pack;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } seq_state_t;

   localparam int SUB_BASE_DEF   = 100;
   localparam int SUB_STRIDE_DEF = 16;
   localparam int JSR_IDX_W      = 4;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address stack (LIFO), DEPTH entries of W bits.
// The pointer is circular: a push when full overwrites the oldest entry
// and the count saturates at DEPTH; a pop when empty still reads the
// entry at the wrapped pointer and the count stays at 0.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous clear of pointer and count
//   push, pop  : stack operations (pop wins if both are asserted)
//   din        : address to push
//   top        : entry a pop would return (combinational)
//   count      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
module ret_stack
   import instr_pack::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             top,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_dec;

   assign ptr_dec = ptr - PTR_W'(1);
   assign top     = mem[ptr_dec];
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         ptr   <= '0;
         count <= '0;
      end else if (pop) begin
         ptr <= ptr_dec;
         if (!empty) count <= count - CNT_W'(1);
      end else if (push) begin
         ptr <= ptr + PTR_W'(1);
         if (!full) count <= count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !pop && !clr) begin
         mem[ptr] <= din;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the 9-bit CPU. Owns the PC feeding the
// combinational instruction memory and picks the next PC each cycle from
// decoded control (halt > ret > jsr > branch > increment). Subroutine
// return addresses live in a ret_stack instance so calls may nest.
// Optional macro PC_SEQ_STACK_CHECK_EN: stack overflow/underflow moves the
// sequencer to a sticky FAULT state instead of wrapping circularly.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start                 : begin execution at PC 0 (from IDLE/HALT/FAULT)
//   stall                 : hold everything this cycle
//   br_take, br_target    : taken bnzr and its 8-bit target
//   jsr, jsr_idx          : jtsr and subroutine index
//   ret                   : rfsr
//   halt_req              : done instruction
//   pc                    : current instruction address
//   running, done, fault  : state is RUN / HALT / FAULT
//   sp                    : return-stack occupancy
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | fetching/sequencing instructions
// HALT  | done executed, pc parked on it
// FAULT | stack over/underflow (checked build only), pc parked
module pc_sequencer
   import instr_pack::*;
#(
   parameter int PC_W       = 10,
   parameter int DEPTH      = 4,
   parameter int SUB_BASE   = SUB_BASE_DEF,
   parameter int SUB_STRIDE = SUB_STRIDE_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stall,
   input  logic                   br_take,
   input  logic [7:0]             br_target,
   input  logic                   jsr,
   input  logic [JSR_IDX_W-1:0]   jsr_idx,
   input  logic                   ret,
   input  logic                   halt_req,
   output logic [PC_W-1:0]        pc,
   output logic                   running,
   output logic                   done,
   output logic                   fault,
   output logic [$clog2(DEPTH):0] sp
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_RUN   = RUN;
   localparam logic [1:0] S_HALT  = HALT;
   localparam logic [1:0] S_FAULT = FAULT;

   logic [1:0]      state, state_nxt;
   logic [PC_W-1:0] pc_nxt, pc_inc, sub_addr, br_addr, stk_top;
   logic            stk_push, stk_pop, stk_clr, stk_full, stk_empty;

   assign pc_inc   = pc + PC_W'(1);
   assign sub_addr = PC_W'(SUB_BASE) + PC_W'(jsr_idx) * PC_W'(SUB_STRIDE);
   assign br_addr  = {{(PC_W-8){1'b0}}, br_target};

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_clr   = 1'b0;
      case (state)
         S_RUN: begin
            if (!stall) begin
               if (halt_req) begin
                  state_nxt = S_HALT;
               end else if (ret) begin
`ifdef PC_SEQ_STACK_CHECK_EN
                  if (stk_empty) begin
                     state_nxt = S_FAULT;
                  end else
`endif
                  begin
                     stk_pop = 1'b1;
                     pc_nxt  = stk_top;
                  end
               end else if (jsr) begin
`ifdef PC_SEQ_STACK_CHECK_EN
                  if (stk_full) begin
                     state_nxt = S_FAULT;
                  end else
`endif
                  begin
                     stk_push = 1'b1;
                     pc_nxt   = sub_addr;
                  end
               end else if (br_take) begin
                  pc_nxt = br_addr;
               end else begin
                  pc_nxt = pc_inc;
               end
            end
         end
         // IDLE, HALT and FAULT only respond to start
         default: begin
            if (start) begin
               state_nxt = S_RUN;
               pc_nxt    = '0;
               stk_clr   = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         pc    <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   ret_stack #(
      .DEPTH (DEPTH),
      .W     (PC_W)
   ) u_ret_stack (
      .clk   (clk),
      .reset (reset),
      .clr   (stk_clr),
      .push  (stk_push),
      .pop   (stk_pop),
      .din   (pc_inc),
      .top   (stk_top),
      .count (sp),
      .full  (stk_full),
      .empty (stk_empty)
   );

   assign running = (state == S_RUN);
   assign done    = (state == S_HALT);

`ifdef PC_SEQ_STACK_CHECK_EN
   assign fault = (state == S_FAULT);
`else
   assign fault = 1'b0;
   // flags only matter to the checked build
   logic unused_flags;
   assign unused_flags = stk_full ^ stk_empty;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0, stall = 1'b0, br_take = 1'b0, jsr = 1'b0;
   logic       ret = 1'b0, halt_req = 1'b0;
   logic [7:0] br_target = '0;
   logic [3:0] jsr_idx = '0;
   logic [9:0] pc;
   logic       running, done, fault;
   logic [2:0] sp;

   pc_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stall     (stall),
      .br_take   (br_take),
      .br_target (br_target),
      .jsr       (jsr),
      .jsr_idx   (jsr_idx),
      .ret       (ret),
      .halt_req  (halt_req),
      .pc        (pc),
      .running   (running),
      .done      (done),
      .fault     (fault),
      .sp        (sp)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      logic [9:0] pc;
      logic       run;
      logic       dn;
      logic       flt;
      logic [2:0] sp;
   } exp_t;

   exp_t q[$];
   int   n_total = 0;
   int   n_pass  = 0;

`ifdef PC_SEQ_STACK_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   // Monitor: one registered output set per cycle, checked against the
   // expectation queued by the stimulus for that edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_total++;
            if (pc === e.pc && running === e.run && done === e.dn &&
                fault === e.flt && sp === e.sp) begin
               n_pass++;
            end else begin
               $display("FAIL %s: got pc=%0d run=%b done=%b fault=%b sp=%0d, want pc=%0d run=%b done=%b fault=%b sp=%0d",
                        e.nm, pc, running, done, fault, sp,
                        e.pc, e.run, e.dn, e.flt, e.sp);
            end
         end
      end
   end

   task automatic cyc(input logic rs, input logic st, input logic sl,
                      input logic bt, input logic [7:0] bg,
                      input logic j, input logic [3:0] ji,
                      input logic r, input logic h,
                      input string nm, input logic [9:0] epc,
                      input logic erun, input logic edn, input logic eflt,
                      input logic [2:0] esp);
      exp_t e;
      @(negedge clk);
      reset = rs; start = st; stall = sl; br_take = bt; br_target = bg;
      jsr = j; jsr_idx = ji; ret = r; halt_req = h;
      e.nm = nm; e.pc = epc; e.run = erun; e.dn = edn; e.flt = eflt; e.sp = esp;
      q.push_back(e);
   endtask

   // shorthands: plain RUN-state step and expectation
   task automatic run_step(input logic bt, input logic [7:0] bg,
                           input logic j, input logic [3:0] ji,
                           input logic r, input logic h, input logic sl,
                           input string nm, input logic [9:0] epc,
                           input logic [2:0] esp);
      cyc(0, 0, sl, bt, bg, j, ji, r, h, nm, epc, 1, 0, 0, esp);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
      $fatal(1, "timeout");
   end

   initial begin
      // reset and idle
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, "reset", 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 8'd33, 1, 0, 0, 0, "idle_ignores", 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, "start", 0, 1, 0, 0, 0);
      for (int i = 1; i <= 4; i++) run_step(0, 0, 0, 0, 0, 0, 0, "incr", 10'(i), 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, "start_in_run", 5, 1, 0, 0, 0);

      // branches and stall
      run_step(1, 8'd94, 0, 0, 0, 0, 0, "br94", 94, 0);
      run_step(1, 8'd9, 0, 0, 0, 0, 0, "br9", 9, 0);
      for (int i = 0; i < 3; i++) run_step(1, 8'd77, 1, 3, 0, 1, 1, "stall", 9, 0);
      run_step(1, 8'd45, 0, 0, 0, 0, 0, "br45", 45, 0);

      // single call / return
      run_step(0, 0, 1, 0, 0, 0, 0, "jsr0", 100, 1);
      run_step(1, 8'd112, 0, 0, 0, 0, 0, "br112", 112, 1);
      run_step(0, 0, 0, 0, 1, 0, 0, "ret46", 46, 0);

      // nested
      run_step(0, 0, 1, 0, 0, 0, 0, "nest_jsr0", 100, 1);
      run_step(0, 0, 1, 1, 0, 0, 0, "nest_jsr1", 116, 2);
      run_step(0, 0, 0, 0, 1, 0, 0, "nest_ret101", 101, 1);
      run_step(0, 0, 0, 0, 1, 0, 0, "nest_ret47", 47, 0);

      // jsr+ret together: ret wins, no push
      run_step(0, 0, 1, 2, 0, 0, 0, "jsr2", 132, 1);
      run_step(0, 0, 1, 3, 1, 0, 0, "ret_beats_jsr", 48, 0);

      // halt (priority over jsr), ignore in HALT, restart
      run_step(1, 8'd95, 0, 0, 0, 0, 0, "br95", 95, 0);
      cyc(0, 0, 0, 0, 0, 1, 1, 0, 1, "halt", 95, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 8'd7, 1, 0, 1, 0, "halt_ignores", 95, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, "restart", 0, 1, 0, 0, 0);

      // wrap: call sub15 (340) from pc0, count up to 1023
      run_step(0, 0, 1, 15, 0, 0, 0, "jsr15", 340, 1);
      for (int i = 341; i <= 1023; i++) run_step(0, 0, 0, 0, 0, 0, 0, "count_up", 10'(i), 1);
      run_step(0, 0, 1, 0, 0, 0, 0, "jsr_at_1023", 100, 2);
      run_step(0, 0, 0, 0, 1, 0, 0, "ret_wrapped0", 0, 1);
      run_step(0, 0, 0, 0, 1, 0, 0, "ret_to1", 1, 0);

      // DEPTH+1 nested calls
      run_step(0, 0, 1, 0, 0, 0, 0, "deep1", 100, 1);
      run_step(0, 0, 1, 0, 0, 0, 0, "deep2", 100, 2);
      run_step(0, 0, 1, 0, 0, 0, 0, "deep3", 100, 3);
      run_step(0, 0, 1, 0, 0, 0, 0, "deep4", 100, 4);
      if (CHK) begin
         cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, "overflow_fault", 100, 0, 0, 1, 4);
         cyc(0, 0, 0, 1, 8'd5, 1, 1, 1, 1, "fault_sticky", 100, 0, 0, 1, 4);
         cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, "fault_start", 0, 1, 0, 0, 0);
         cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, "underflow_fault", 0, 0, 0, 1, 0);
         cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, "fault_start2", 0, 1, 0, 0, 0);
      end else begin
         run_step(0, 0, 1, 0, 0, 0, 0, "overflow_wrap", 100, 4);
         // oldest entry (return to 2) was overwritten; every pop yields 101
         for (int i = 3; i >= 0; i--) run_step(0, 0, 0, 0, 1, 0, 0, "unwind", 101, 3'(i));
         run_step(0, 0, 0, 0, 1, 0, 0, "pop_empty", 101, 0);
      end

      // reset mid-subroutine overrides start and controls
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset2", 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, "start3", 0, 1, 0, 0, 0);
      run_step(0, 0, 1, 1, 0, 0, 0, "jsr1_b", 116, 1);
      cyc(1, 1, 0, 1, 8'd3, 1, 2, 0, 0, "reset_mid_sub", 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_after_reset", 0, 0, 0, 0, 0);

      // let the monitor drain, bounded
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_total++;
         $display("FAIL drain: queue still holds %0d, want 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
